pipelined_carry_adder: RTL and testbench

Parametrised, pipelined successor to the combinational ripple adder. It splits a WIDTH-bit add/subtract into STAGES registered carry-ripple segments and sustains one operation per cycle under a valid/ready handshake with full back-pressure. It sits between operand producers (register file, DSP datapath) and consumers that may stall. It also reports unsigned carry/borrow and signed overflow.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_segment.sv | 42 ++++
 rtl/full_adder.sv | 20 ++
 rtl/pipelined_carry_adder.sv | 155 +++++++++++++++
 tb/tb_pipelined_carry_adder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined carry adder:
//   OP_ADD / OP_SUB      : encoding of the 'sub' operation select input
//   seg_width(w, s)      : bits per pipeline segment (w / s)
//   seg_legal(w, s)      : 1 when a WIDTH/STAGES pair can be built
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Every segment must have the same width, so STAGES has to divide WIDTH.
    function automatic bit seg_legal(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// -----------------------------------------------------------------------------
// adder_segment
// SEG-bit combinational ripple-carry adder built from full_adder cells.
//   a, b : SEG-bit operands (b already inverted for subtraction upstream)
//   cin  : carry into bit 0
//   sum  : SEG-bit sum
//   cout : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // Each bit keeps its own carry wires in its generate scope so the chain
    // is a plain series of scalar nets rather than one self-referencing vector.
    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
        logic ci_w;
        logic co_w;

        if (gi == 0) begin : g_first
            assign ci_w = cin;
        end else begin : g_rest
            assign ci_w = g_bit[gi-1].co_w;
        end

        full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (ci_w),
            .s  (sum[gi]),
            .co (co_w)
        );
    end

    assign cout = g_bit[SEG-1].co_w;

endmodule

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
// WIDTH-bit add/subtract split into STAGES registered ripple segments with a
// valid/ready handshake and full back-pressure (no skid buffer).
//   clk, rst   : clock (rising edge) and asynchronous active-high reset
//   in_valid   : operand beat present        in_ready  : beat can be taken
//   a, b       : operands                    cin       : carry / borrow in
//   sub        : 0 = a+b+cin, 1 = a-b-cin
//   out_valid  : result present              out_ready : consumer takes result
//   sum        : result mod 2^WIDTH          cout      : raw MSB carry
//   ovf        : two's-complement overflow
// Stage k adds segment k using the carry registered by stage k-1. Operand
// segments not yet consumed and result segments already produced ride along
// in each stage's registers.
// -----------------------------------------------------------------------------
module pipelined_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!seg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-stage registers: valid, operand A, effective operand B, partial sum,
    // carry out of the segment this stage computed.
    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  bp_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    // What each stage would load: the input port for stage 0, the previous
    // stage's registers otherwise.
    logic [STAGES-1:0] v_src;
    logic [STAGES-1:0] c_src;
    logic [WIDTH-1:0]  a_src   [STAGES];
    logic [WIDTH-1:0]  bp_src  [STAGES];
    logic [WIDTH-1:0]  sum_src [STAGES];

    logic [WIDTH-1:0]  seg_sum_all;
    logic [STAGES-1:0] seg_cout_all;

    // adv[k] = stage k may load this cycle; adv[STAGES] is the consumer.
    logic [STAGES:0]   adv;

    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    // Subtraction is A + ~B + ~cin, so borrow-in maps to an inverted carry-in.
    always_comb begin
        v_src      = '0;
        c_src      = '0;
        v_src[0]   = in_valid;
        c_src[0]   = (sub == OP_SUB) ? ~cin : cin;
        a_src[0]   = a;
        bp_src[0]  = (sub == OP_SUB) ? ~b : b;
        sum_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k]   = v_q[k-1];
            c_src[k]   = c_q[k-1];
            a_src[k]   = a_q[k-1];
            bp_src[k]  = bp_q[k-1];
            sum_src[k] = sum_q[k-1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        adder_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (a_src[gi][gi*SEG +: SEG]),
            .b    (bp_src[gi][gi*SEG +: SEG]),
            .cin  (c_src[gi]),
            .sum  (seg_sum_all[gi*SEG +: SEG]),
            .cout (seg_cout_all[gi])
        );
    end

    // A stage that is allowed to advance takes its source (even a bubble);
    // otherwise it holds, which keeps a stalled output stable.
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            bp_d[k]  = bp_q[k];
            sum_d[k] = sum_q[k];
            if (adv[k]) begin
                v_d[k]                 = v_src[k];
                c_d[k]                 = seg_cout_all[k];
                a_d[k]                 = a_src[k];
                bp_d[k]                = bp_src[k];
                sum_d[k]               = sum_src[k];
                sum_d[k][k*SEG +: SEG] = seg_sum_all[k*SEG +: SEG];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            bp_q  <= bp_d;
            sum_q <= sum_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];
    // Overflow when both effective operands share a sign the result lacks.
    // All three registers clear on reset, so ovf reads 0 after reset.
    assign ovf = (a_q[LAST][WIDTH-1] == bp_q[LAST][WIDTH-1]) &&
                 (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_carry_adder.sv
module tb_pipelined_carry_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] a_i, b_i;
    logic        cin_i, sub_i;
    logic [2:0]  iv, ordy, ir, ov, co, of;
    logic [15:0] s_o [3];

    int n_checks = 0;
    int n_errors = 0;
    res_t q [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three builds side by side: STAGES=4 (main), 1 and 16 (corner configs).
    pipelined_carry_adder #(.WIDTH(16), .STAGES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s_o[0]), .cout(co[0]), .ovf(of[0]));

    pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s_o[1]), .cout(co[1]), .ovf(of[1]));

    pipelined_carry_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s_o[2]), .cout(co[2]), .ovf(of[2]));

    function automatic int lat_of(input int idx);
        case (idx)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference: plain 17-bit arithmetic, overflow from operand/result signs.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [16:0] t;
        if (sub) begin
            t     = {1'b0, a} + {1'b0, ~b} + {16'd0, ~cin};
            r.ovf = (a[15] != b[15]) && (t[15] != a[15]);
        end else begin
            t     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            r.ovf = (a[15] == b[15]) && (t[15] != a[15]);
        end
        r.sum  = t[15:0];
        r.cout = t[16];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: transfers happen at the next rising edge, so sample the
    // handshakes on the falling edge while everything is settled.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && ordy[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_output", i), 32'd1, 32'd0);
                    end else begin
                        res_t e;
                        e = q[i].pop_front();
                        chk($sformatf("dut%0d_sum", i), {16'd0, s_o[i]}, {16'd0, e.sum});
                        chk($sformatf("dut%0d_cout", i), {31'd0, co[i]}, {31'd0, e.cout});
                        chk($sformatf("dut%0d_ovf", i), {31'd0, of[i]}, {31'd0, e.ovf});
                    end
                end
                if (iv[i] && ir[i]) q[i].push_back(model(a_i, b_i, cin_i, sub_i));
            end
        end
    end

    task automatic rand_ops();
        a_i   = 16'($urandom);
        b_i   = 16'($urandom);
        cin_i = 1'($urandom_range(0, 1));
        sub_i = 1'($urandom_range(0, 1));
    endtask

    // Single beat into one DUT; checks latency and the result fields.
    task automatic send_and_check(input int idx, input vec_t v);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        a_i = v.a; b_i = v.b; cin_i = v.cin; sub_i = v.sub;
        iv[idx] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            iv[idx] = 1'b0;
            cyc++;
            if (ov[idx]) begin
                seen = 1;
                break;
            end
        end
        chk($sformatf("dut%0d_latency", idx), 32'(cyc), 32'(lat_of(idx)));
        if (seen) begin
            chk($sformatf("dut%0d_vec_sum", idx), {16'd0, s_o[idx]}, {16'd0, v.sum});
            chk($sformatf("dut%0d_vec_cout", idx), {31'd0, co[idx]}, {31'd0, v.cout});
            chk($sformatf("dut%0d_vec_ovf", idx), {31'd0, of[idx]}, {31'd0, v.ovf});
        end
    endtask

    task automatic drain();
        iv   = 3'b000;
        ordy = 3'b111;
        for (int c = 0; c < 60; c++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_drain_empty", i), 32'(q[i].size()), 32'd0);
            chk($sformatf("dut%0d_drain_ov", i), {31'd0, ov[i]}, 32'd0);
        end
    endtask

    vec_t vecs [9];

    initial begin
        int   acc;
        logic [15:0] held_sum;
        logic held_co, held_of;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; iv = 3'b000; ordy = 3'b111;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d_rst_ov", i), {31'd0, ov[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_sum", i), {16'd0, s_o[i]}, 32'd0);
            chk($sformatf("dut%0d_rst_ir", i), {31'd0, ir[i]}, 32'd1);
        end
        rst = 1'b0;

        // Reset with three beats in flight, the oldest parked at the output.
        ordy = 3'b000;
        for (int j = 0; j < 3; j++) begin
            a_i = 16'h1111 * 16'(j + 1); b_i = 16'h0101;
            iv[0] = 1'b1;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_ov", {31'd0, ov[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ov", {31'd0, ov[0]}, 32'd0);
        chk("async_rst_sum", {16'd0, s_o[0]}, 32'd0);
        chk("async_rst_cout", {31'd0, co[0]}, 32'd0);
        chk("async_rst_ovf", {31'd0, of[0]}, 32'd0);
        chk("async_rst_ir", {31'd0, ir[0]}, 32'd1);
        for (int i = 0; i < 3; i++) q[i].delete();
        @(posedge clk); #1;
        rst  = 1'b0;
        ordy = 3'b111;

        // Directed vectors on every configuration, with latency check.
        for (int idx = 0; idx < 3; idx++) begin
            for (int k = 0; k < 9; k++) send_and_check(idx, vecs[k]);
        end
        drain();

        // Back-to-back streaming, out_ready held high.
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            iv = 3'b111;
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d_stream_ir", d), {31'd0, ir[d]}, 32'd1);
                if (i >= lat_of(d))
                    chk($sformatf("dut%0d_stream_ov", d), {31'd0, ov[d]}, 32'd1);
            end
            @(posedge clk); #1;
        end
        drain();

        // Fill the 4-stage pipe against a stalled consumer.
        ordy[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            rand_ops();
            iv[0] = 1'b1;
            if (!ir[0]) break;
            @(posedge clk); #1;
            acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd4);
        held_sum = s_o[0]; held_co = co[0]; held_of = of[0];
        for (int c = 0; c < 10; c++) begin
            rand_ops();
            @(posedge clk); #1;
            chk("stall_ov", {31'd0, ov[0]}, 32'd1);
            chk("stall_ir", {31'd0, ir[0]}, 32'd0);
            chk("stall_sum", {16'd0, s_o[0]}, {16'd0, held_sum});
            chk("stall_cout_ovf", {30'd0, co[0], of[0]}, {30'd0, held_co, held_of});
        end
        drain();

        // Random valid/ready toggling on all three configurations.
        for (int c = 0; c < 1000; c++) begin
            rand_ops();
            iv   = {3{1'($urandom_range(0, 1))}};
            ordy = {3{1'($urandom_range(0, 1))}};
            @(posedge clk); #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
